program_loader: RTL
===================

# program_loader

Serial-stream program loader for the SAP-2 computer. Accepts a framed byte stream (header, length, payload, checksum) over a valid/ready byte interface, typically fed by a UART receiver. It writes the payload into program RAM starting at address 0 and holds the CPU in reset until a load completes with a good checksum. This replaces `$readmemh` preloading on hardware. It sits between the byte source and the RAM write port, alongside `computer`.

## Interface
- `ADDR_WIDTH`, default `arch_defs_pkg::ADDR_WIDTH` (4): RAM address width.
- `DATA_WIDTH`, default `arch_defs_pkg::DATA_WIDTH` (8): byte width; must be 8.
- `TIMEOUT_CYCLES`, default 1000: inactivity limit; used only with `LOADER_TIMEOUT_EN`.

Ports (name, direction, width, meaning):
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0). One clock only.
- `rx_data_i`  in  8  incoming byte.
- `rx_valid_i`  in  1  byte available.
- `rx_ready_o`  out  1  loader can accept a byte.
- `ram_we_o`  out  1  RAM write strobe, one cycle per payload byte.
- `ram_addr_o`  out  ADDR_WIDTH  RAM write address.
- `ram_data_o`  out  8  RAM write data.
- `cpu_hold_o`  out  1  drives CPU reset; 1 means the CPU is held.
- `load_done_o`  out  1  last load succeeded.
- `load_error_o`  out  1  last load failed.

## Operation
- Frame: `HEADER` (8'hA5), `LEN`, `LEN` payload bytes, `CSUM`.
- `CSUM` is chosen so that (sum of payload + `CSUM`) mod 256 == 0.
- A byte is accepted on a rising edge where `rx_valid_i && rx_ready_o`.

States:
- `IDLE`: a header moves to `LEN`; any other byte is consumed and ignored.
- `LEN`:
  - `LEN` == 0 or `LEN` > 2^ADDR_WIDTH moves to `ERROR`.
  - Otherwise: latch the length, clear the address counter and the 8-bit running sum, move to `DATA`.
- `DATA`:
  - Each accepted byte is written to the current address, added to the sum (mod 256), and the address increments.
  - After `LEN` bytes, move to `CSUM`.
  - `LEN` == 2^ADDR_WIDTH fills the RAM. The address wraps to 0 internally, but no write occurs at the wrapped address.
- `CSUM`: (sum + byte) mod 256 == 0 moves to `DONE`; otherwise to `ERROR`.
- `DONE` / `ERROR`:
  - A header clears `load_done_o` and `load_error_o`, asserts `cpu_hold_o`, and moves to `LEN`.
  - Any other byte is ignored.

Outputs:
- `cpu_hold_o` is 1 in every state except `DONE`.
- `load_done_o` is 1 only in `DONE`; `load_error_o` is 1 only in `ERROR`.
- RAM outside 0..`LEN`-1 is not touched.

## Timing
Reset values:
- State = `IDLE`.
- `rx_ready_o` = 0 while `reset` is asserted, 1 from the first cycle after release.
- `ram_we_o` = 0, `ram_addr_o` = 0, `ram_data_o` = 0.
- `cpu_hold_o` = 1, `load_done_o` = 0, `load_error_o` = 0.

Cycle-level rules:
- `ram_we_o`, `ram_addr_o` and `ram_data_o` are registered. The strobe is high for exactly the one cycle after a payload byte is accepted.
- `rx_ready_o` is low during that write cycle, so `DATA` accepts at most one byte per 2 cycles. In all other states `rx_ready_o` = 1 (single-cycle acceptance).
- State outputs change on the edge that accepts the deciding byte. `load_done_o` / `load_error_o` / `cpu_hold_o` are valid in the cycle after the `CSUM` or bad-`LEN` acceptance edge.
- Reset mid-load: asynchronously returns to `IDLE` and forces `ram_we_o` to 0. An in-flight write is dropped, and the CPU stays held.
- `rx_valid_i` low: the FSM holds its state indefinitely, unless the timeout is compiled in.

## Configuration
- `LOADER_TIMEOUT_EN` defined:
  - A counter runs while in `LEN`, `DATA` or `CSUM` and clears on every accepted byte.
  - When it reaches `TIMEOUT_CYCLES` with no byte accepted, the FSM moves to `ERROR` (`load_error_o` = 1, CPU held).
  - Timeout takes priority over a byte presented on the same edge.
- Undefined: no counter, no timeout, and `TIMEOUT_CYCLES` is ignored.

## Structure
- `arch_defs_pkg` gets:
  - `loader_state_t` enum (`IDLE`, `LEN`, `DATA`, `CSUM`, `DONE`, `ERROR`).
  - `LOADER_HEADER` = 8'hA5.
- Single flat module; no sub-module. The address counter, running sum and optional timeout counter are inline.
- `computer` integration: `cpu_hold_o` is ORed into the CPU reset, and `ram_*` are muxed into the `u_ram` write port while the CPU is held.

## Test plan
- **Nominal load:** reset, then A5 03 11 22 33 9A → RAM[0..2] = 11, 22, 33; `load_done_o` = 1; `cpu_hold_o` = 0; exactly 3 `ram_we_o` pulses.
- **Bad checksum:** A5 02 01 02 00 → `load_error_o` = 1, `cpu_hold_o` = 1, `load_done_o` = 0.
- **Length rejects:**
  - A5 00 → `ERROR`.
  - A5 11 (17 > 16) → `ERROR`, no RAM writes.
  - A5 10 with 16 bytes 01 and `CSUM` F0 → `DONE`, RAM[15] = 01.
- **Garbage and retry:**
  - FF 00 A5 01 07 F9 → leading bytes ignored, RAM[0] = 07, `DONE`.
  - A second frame sent after `DONE` re-asserts `cpu_hold_o` on its header.
- **Reset mid-payload:** assert `reset` after 2 of 4 payload bytes → all outputs at reset values immediately; RAM[2..3] unwritten; a following full frame succeeds.
- **`LOADER_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 20:** A5 04 01, then idle 20 cycles → `load_error_o` = 1. Without the macro, the state stays `DATA` after 100 idle cycles.

Source files
------------

// File: rtl/arch_defs_pkg.sv
// rtl/arch_defs_pkg.sv - SAP-2 architecture constants and program loader types
package arch_defs_pkg;

  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 8;

  localparam logic [7:0] LOADER_HEADER = 8'hA5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed serial program loader for SAP-2 RAM (optional LOADER_TIMEOUT_EN)
module program_loader
  import arch_defs_pkg::*;
#(
  parameter int ADDR_WIDTH     = arch_defs_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH     = arch_defs_pkg::DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic                  cpu_hold_o,
  output logic                  load_done_o,
  output logic                  load_error_o
);

  // Frame lengths are bytes, so the RAM must be no larger than 256 entries.
  if (DATA_WIDTH != 8 || ADDR_WIDTH > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("program_loader: unsupported parameter set");
  end

  localparam logic [8:0] LEN_MAX = 9'(1 << ADDR_WIDTH);

  loader_state_t         state_q, state_d;
  logic [8:0]            len_q, len_d;
  logic [8:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            sum_q, sum_d;
  logic                  we_d;
  logic [ADDR_WIDTH-1:0] waddr_d;
  logic [7:0]            wdata_d;
  logic                  accept;
  logic                  is_header;

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  // Ready drops during the RAM write cycle so DATA takes one byte per two cycles.
  assign rx_ready_o   = reset && !ram_we_o;
  assign accept       = rx_valid_i && rx_ready_o;
  assign is_header    = (rx_data_i == LOADER_HEADER);

  assign cpu_hold_o   = (state_q != DONE);
  assign load_done_o  = (state_q == DONE);
  assign load_error_o = (state_q == ERROR);

  // State, counters and the registered RAM write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      sum_q      <= '0;
      ram_we_o   <= 1'b0;
      ram_addr_o <= '0;
      ram_data_o <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      sum_q      <= sum_d;
      ram_we_o   <= we_d;
      ram_addr_o <= waddr_d;
      ram_data_o <= wdata_d;
    end
  end

`ifdef LOADER_TIMEOUT_EN
  // Inactivity counter for the in-frame states.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  // Frame parser: next state, address/sum bookkeeping and write requests.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    waddr_d = ram_addr_o;
    wdata_d = ram_data_o;

    case (state_q)
      IDLE: begin
        if (accept && is_header) state_d = LEN;
      end
      LEN: begin
        if (accept) begin
          if (rx_data_i == 8'd0 || {1'b0, rx_data_i} > LEN_MAX) begin
            state_d = ERROR;
          end else begin
            len_d   = {1'b0, rx_data_i};
            cnt_d   = '0;
            addr_d  = '0;
            sum_d   = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = rx_data_i;
          // A full-RAM frame wraps the counter to 0, but CSUM follows so nothing is written there.
          addr_d  = addr_q + 1'b1;
          sum_d   = sum_q + rx_data_i;
          cnt_d   = cnt_q + 9'd1;
          if (cnt_q + 9'd1 == len_q) state_d = CSUM;
        end
      end
      CSUM: begin
        if (accept) state_d = (8'(sum_q + rx_data_i) == 8'd0) ? DONE : ERROR;
      end
      DONE, ERROR: begin
        if (accept && is_header) state_d = LEN;
      end
      default: state_d = IDLE;
    endcase

`ifdef LOADER_TIMEOUT_EN
    tmo_d = '0;
    if (state_q == LEN || state_q == DATA || state_q == CSUM) begin
      // An expiring timeout wins over a byte arriving on the same edge.
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = ERROR;
        we_d    = 1'b0;
        waddr_d = ram_addr_o;
        wdata_d = ram_data_o;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        sum_d   = sum_q;
      end else if (!accept) begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

endmodule
